seq_alu: RTL and testbench

//  Parametrised, registered successor of the lab 4-bit ALU: add, reduce-OR, reduce-AND, concat

---
 rtl/seq_alu.sv | 106 ++++++++++
 tb/tb_seq_alu.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered 2*WIDTH-bit ALU: single-cycle add/or/and/concat/accumulate and a
// multi-cycle shift-add multiply, with a Start/Busy/Done handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           Function,
  output logic [2*WIDTH-1:0]   ALUout,
  output logic                 Busy,
  output logic                 Done
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nx;
  logic [RW-1:0]    mcand, mcand_nx;
  logic [RW-1:0]    product, product_nx;
  logic [WIDTH-1:0] mplier, mplier_nx;
  logic [CW-1:0]    count, count_nx;
  logic [RW-1:0]    alu_nx;
  logic             busy_nx, done_nx;
  logic [WIDTH:0]   sum;
  logic [RW-1:0]    step_sum;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      mcand   <= '0;
      product <= '0;
      mplier  <= '0;
      count   <= '0;
      ALUout  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nx;
      mcand   <= mcand_nx;
      product <= product_nx;
      mplier  <= mplier_nx;
      count   <= count_nx;
      ALUout  <= alu_nx;
      Busy    <= busy_nx;
      Done    <= done_nx;
    end
  end

  always_comb begin
    sum        = {1'b0, A} + {1'b0, B};
    step_sum   = product + (mplier[0] ? mcand : '0);
    state_nx   = state;
    mcand_nx   = mcand;
    product_nx = product;
    mplier_nx  = mplier;
    count_nx   = count;
    alu_nx     = ALUout;
    busy_nx    = Busy;
    done_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (Start) begin
          done_nx = 1'b1;
          case (Function)
            3'b000: alu_nx = {{(RW-WIDTH-1){1'b0}}, sum};
            3'b001: alu_nx = {{(RW-1){1'b0}}, |{A, B}};
            3'b010: alu_nx = {{(RW-1){1'b0}}, &{A, B}};
            3'b011: alu_nx = {A, B};
            3'b100: begin
              mcand_nx   = {{WIDTH{1'b0}}, A};
              mplier_nx  = B;
              product_nx = '0;
              count_nx   = '0;
              state_nx   = MUL;
              busy_nx    = 1'b1;
              done_nx    = 1'b0;
            end
            3'b101: alu_nx = ALUout + {{WIDTH{1'b0}}, A};
            default: alu_nx = '0;
          endcase
        end
      end
      MUL: begin
        product_nx = step_sum;
        mcand_nx   = mcand << 1;
        mplier_nx  = mplier >> 1;
        count_nx   = count + CW'(1);
        // Final step: step_sum already includes the last partial product.
        if (count == CW'(WIDTH - 1)) begin
          alu_nx   = step_sum;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=4): expected results are queued at issue,
// a monitor pops and compares on each Done pulse.
module tb_seq_alu;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [2:0] Function = '0;
  logic [7:0] ALUout;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  localparam logic [2:0] F_ADD = 3'b000, F_OR = 3'b001, F_AND = 3'b010,
                         F_CAT = 3'b011, F_MUL = 3'b100, F_ACC = 3'b101;

  seq_alu #(.WIDTH(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .A(A), .B(B),
    .Function(Function), .ALUout(ALUout), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every Done cycle must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (Done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got Done=1 ALUout=%h expected no Done", ALUout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ALUout !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h", ALUout, e);
        end
      end
    end
  end

  // Called just after a negedge; drives one Start cycle and returns at the next negedge.
  task automatic issue(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] e, input bit push);
    Function = f; A = a; B = b; Start = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge Clock);
    Start = 1'b0;
  endtask

  initial begin
    int busy_cnt;

    repeat (2) @(negedge Clock);
    check("reset_aluout", ALUout, 8'h00);
    check("reset_busy", {7'b0, Busy}, 8'h00);
    check("reset_done", {7'b0, Done}, 8'h00);
    Resetn = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      check("idle_aluout", ALUout, 8'h00);
      check("idle_busy", {7'b0, Busy}, 8'h00);
      check("idle_done", {7'b0, Done}, 8'h00);
    end

    issue(F_ADD, 4'hF, 4'h1, 8'h10, 1);
    check("add_done_pulse", {7'b0, Done}, 8'h01);
    check("add_busy", {7'b0, Busy}, 8'h00);
    @(negedge Clock);
    check("add_done_one_cycle", {7'b0, Done}, 8'h00);
    check("add_hold", ALUout, 8'h10);

    issue(F_CAT, 4'hA, 4'h5, 8'hA5, 1);
    issue(F_OR,  4'h0, 4'h0, 8'h00, 1);
    issue(F_AND, 4'hF, 4'hF, 8'h01, 1);
    issue(F_AND, 4'hF, 4'h7, 8'h00, 1);
    issue(F_OR,  4'h0, 4'h2, 8'h01, 1);
    issue(3'b110, 4'h3, 4'h3, 8'h00, 1);
    issue(3'b111, 4'h9, 4'h9, 8'h00, 1);
    @(negedge Clock);

    // Multiply with ignored ADD requests while busy.
    issue(F_MUL, 4'hF, 4'hF, 8'hE1, 1);
    busy_cnt = 0;
    for (int i = 0; i < 10 && Busy === 1'b1; i++) begin
      busy_cnt++;
      check("mul_aluout_held", ALUout, 8'h00);
      Function = F_ADD; A = 4'h1; B = 4'h1; Start = 1'b1;
      @(negedge Clock);
    end
    Start = 1'b0;
    check("mul_busy_cycles", 8'(busy_cnt), 8'd4);
    check("mul_final", ALUout, 8'hE1);
    @(negedge Clock);
    check("mul_no_extra", ALUout, 8'hE1);

    issue(F_CAT, 4'hF, 4'h8, 8'hF8, 1);
    issue(F_ACC, 4'hF, 4'h0, 8'h07, 1);
    issue(3'b111, 4'h0, 4'h0, 8'h00, 1);
    issue(F_ACC, 4'h3, 4'h0, 8'h03, 1);
    issue(F_ACC, 4'h3, 4'h0, 8'h06, 1);
    issue(F_ACC, 4'h3, 4'h0, 8'h09, 1);
    @(negedge Clock);
    check("acc_hold", ALUout, 8'h09);

    // Reset aborts an in-progress multiply without a Done.
    issue(F_MUL, 4'h7, 4'h3, 8'h00, 0);
    @(negedge Clock);
    check("mul2_busy_before_reset", {7'b0, Busy}, 8'h01);
    Resetn = 1'b0;
    #1;
    check("abort_aluout", ALUout, 8'h00);
    check("abort_busy", {7'b0, Busy}, 8'h00);
    check("abort_done", {7'b0, Done}, 8'h00);
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    repeat (6) @(negedge Clock);
    check("post_abort_aluout", ALUout, 8'h00);

    issue(F_MUL, 4'h7, 4'h3, 8'h15, 1);
    for (int i = 0; i < 10 && Busy === 1'b1; i++) @(negedge Clock);
    check("mul3_idle", {7'b0, Busy}, 8'h00);
    check("mul3_result", ALUout, 8'h15);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clock);
    check("outstanding_results", 8'(exp_q.size()), 8'd0);
    repeat (2) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
